alu_exec: RTL and testbench
===========================

# alu_exec

Multi-cycle execute unit for the RISC-V core, directly downstream of the ALU controller. It consumes the 4-bit `alu_control` code plus two operands and produces the result under a valid/ready handshake. Add, subtract, logic and compare ops complete in one cycle. Shifts use a serial 1-bit-per-cycle shifter to save area, so the EX stage must tolerate variable latency.

## Interface
Parameters:
- `XLEN`, 32 — datapath width; 32 or 64. Shift amount is `op_b[$clog2(XLEN)-1:0]`.

Ports:
- `clk`  in  1  — single clock, all state on rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `in_valid`  in  1  — operation offered.
- `in_ready`  out  1  — block can accept an operation.
- `alu_control`  in  4  — op code: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9. Codes 10–15 are undefined.
- `op_a`  in  XLEN  — operand A (rs1).
- `op_b`  in  XLEN  — operand B (rs2 or immediate).
- `flush`  in  1  — synchronous kill of the in-flight op.
- `out_valid`  out  1  — `result` is valid.
- `out_ready`  in  1  — consumer takes the result.
- `result`  out  XLEN  — registered result.
- `zero`  out  1  — `result == 0`; drives branch compare.
- `busy`  out  1  — state is SHIFT.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Handshake:
  - Accept occurs when `in_valid && in_ready`.
  - `in_ready = (state==IDLE) || (state==DONE && out_ready)`. This is a combinational path from `out_ready`, which allows back-to-back single-cycle ops.
  - Inputs are sampled only at accept and need not be held afterwards.
- On accept, non-shift op:
  - `result` is loaded with the op value; next state is DONE.
  - SLT is a signed compare; SLTU is unsigned. Both give 1 or 0, zero-extended.
  - ADD and SUB wrap modulo 2^XLEN.
  - Undefined codes give `result = 0`, timed as a non-shift op.
- On accept, shift op (SLL, SRL, SRA) with shamt k:
  - If k==0: `result = op_a`; next state is DONE.
  - Else: the shift register loads `op_a`, the count loads k, the op is latched; next state is SHIFT.
- In SHIFT, every cycle:
  - Shift 1 bit: SLL fills 0 at LSB, SRL fills 0 at MSB, SRA replicates the MSB.
  - Decrement the count.
  - When the count goes from 1 to 0, the shifted value is written to `result`; next state is DONE.
  - `in_ready=0` and `out_valid=0` throughout.
- In DONE:
  - `out_valid=1`; `result` and `zero` are held stable until `out_ready`.
  - `out_ready` without a new accept: next state is IDLE.
  - `out_ready` with a new accept: the new op starts, with no bubble.
- `flush` (takes priority over everything except reset):
  - Next state is IDLE and `out_valid` drops next cycle.
  - `result` is unchanged; any simultaneous accept is discarded.
- Reset, in any state including mid-shift:
  - State is IDLE; `out_valid=0`, `result=0`, `zero=1`, `busy=0`, count=0.
  - `in_ready=1` immediately after reset release.

## Timing
- Latency is measured from the accept edge E.
  - Non-shift op, or shift with k==0: `out_valid` is high in the cycle after E.
  - Shift with k≥1: `out_valid` is high k+1 cycles after E, with `busy` high for those k cycles.
- Throughput:
  - One non-shift op per cycle while `out_ready=1`.
  - A shift occupies the block for k+1 cycles plus the handshake.
- Backpressure:
  - With `out_ready=0`, DONE persists indefinitely.
  - `in_ready=0` for as long as DONE persists.
- Max shift is k=XLEN-1, giving XLEN cycles of latency.

## Test plan
- Reset then ADD, op_a=5, op_b=7, `out_ready=1` -> `out_valid` high the next cycle with result=12 and zero=0; then SUB 3−5 accepted on the following edge -> result=0xFFFFFFFE.
- SLT and SLTU with op_a=0xFFFFFFFF, op_b=1 -> SLT result=1, SLTU result=0. SUB 9−9 -> result=0, zero=1.
- SRA op_a=0x80000000, op_b=4 -> `busy` high for 4 cycles; `out_valid` 5 cycles after accept; result=0xF8000000. SRL with the same inputs -> 0x08000000. SLL op_a=1, op_b=31 -> 0x80000000 after 32 cycles.
- Backpressure: ADD result pending with `out_ready=0` for 3 cycles while `in_valid=1` -> `in_ready=0` and result held stable; `out_ready=1` -> result taken and new op accepted the same edge.
- `rst_n` asserted mid-SRL, with k=20 at count 10 -> outputs immediately go to reset values, asynchronously. `flush` in SHIFT -> IDLE next cycle with no `out_valid` pulse.
- Undefined code 12 -> result=0 and zero=1 one cycle after accept. Shift with k=0 (op_b=0x20, XLEN=32) -> result=op_a one cycle after accept, `busy` never high.

Source files
------------

// File: rtl/alu_exec.sv
// Multi-cycle RISC-V execute unit: single-cycle arithmetic/logic/compare ops,
// serial 1-bit-per-cycle shifter, valid/ready handshake on both sides.
module alu_exec #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_control,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            busy
);

   localparam int SW = $clog2(XLEN);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_SLL  = 4'd2;
   localparam logic [3:0] OP_SLT  = 4'd3;
   localparam logic [3:0] OP_SLTU = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_OR   = 4'd8;
   localparam logic [3:0] OP_AND  = 4'd9;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [XLEN-1:0]   shreg_q, shreg_d;
   logic [SW-1:0]     cnt_q, cnt_d;
   logic [3:0]        shop_q, shop_d;

   logic              accept;
   logic              is_shift;
   logic [SW-1:0]     shamt;
   logic [XLEN-1:0]   alu_val;
   logic [XLEN-1:0]   shifted;

   assign shamt    = op_b[SW-1:0];
   assign is_shift = (alu_control == OP_SLL) || (alu_control == OP_SRL) ||
                     (alu_control == OP_SRA);
   assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
   assign accept   = in_valid && in_ready;

   // Single-cycle op values; shift codes and undefined codes fall to zero here.
   always_comb begin
      alu_val = '0;
      case (alu_control)
         OP_ADD:  alu_val = op_a + op_b;
         OP_SUB:  alu_val = op_a - op_b;
         OP_SLT:  alu_val = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OP_SLTU: alu_val = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         OP_XOR:  alu_val = op_a ^ op_b;
         OP_OR:   alu_val = op_a | op_b;
         OP_AND:  alu_val = op_a & op_b;
         default: alu_val = '0;
      endcase
   end

   always_comb begin
      shifted = shreg_q;
      case (shop_q)
         OP_SLL:  shifted = {shreg_q[XLEN-2:0], 1'b0};
         OP_SRL:  shifted = {1'b0, shreg_q[XLEN-1:1]};
         default: shifted = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
      endcase
   end

   // Flush wins over everything; a new accept in DONE replaces the held result without a bubble.
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      shop_d   = shop_q;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  if (is_shift && (shamt != '0)) begin
                     shreg_d = op_a;
                     cnt_d   = shamt;
                     shop_d  = alu_control;
                     state_d = S_SHIFT;
                  end else begin
                     result_d = is_shift ? op_a : alu_val;
                     state_d  = S_DONE;
                  end
               end else if ((state_q == S_DONE) && out_ready) begin
                  state_d = S_IDLE;
               end
            end
            S_SHIFT: begin
               shreg_d = shifted;
               cnt_d   = cnt_q - SW'(1);
               if (cnt_q == SW'(1)) begin
                  result_d = shifted;
                  state_d  = S_DONE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         shreg_q  <= '0;
         cnt_q    <= '0;
         shop_q   <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
         shop_q   <= shop_d;
      end
   end

   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_SHIFT);
   assign result    = result_q;
   assign zero      = (result_q == '0);

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed ops with literal expectations plus
// a per-cycle comparison against a latency/value model of the execute unit.
module tb_alu_exec;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_control;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        busy;

   int total = 0;
   int bad   = 0;

   // Model state: is a result on offer, how many shift cycles remain, and the values.
   bit          m_valid   = 1'b0;
   int          m_busy    = 0;
   logic [31:0] m_result  = '0;
   logic [31:0] m_pending = '0;

   alu_exec #(.XLEN(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_control (alu_control),
      .op_a        (op_a),
      .op_b        (op_b),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_val(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      int unsigned k;
      k = b[4:0];
      case (c)
         4'd0:    ref_val = a + b;
         4'd1:    ref_val = a - b;
         4'd2:    ref_val = a << k;
         4'd3:    ref_val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd4:    ref_val = (a < b) ? 32'd1 : 32'd0;
         4'd5:    ref_val = a ^ b;
         4'd6:    ref_val = a >> k;
         4'd7:    ref_val = $signed(a) >>> k;
         4'd8:    ref_val = a | b;
         4'd9:    ref_val = a & b;
         default: ref_val = 32'd0;
      endcase
   endfunction

   function automatic int ref_lat(input logic [3:0] c, input logic [31:0] b);
      if (c == 4'd2 || c == 4'd6 || c == 4'd7) ref_lat = int'(b[4:0]);
      else ref_lat = 0;
   endfunction

   // Model update on every edge (or reset), then compare all outputs shortly after.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_valid  = 1'b0;
            m_busy   = 0;
            m_result = '0;
         end else if (flush) begin
            m_valid = 1'b0;
            m_busy  = 0;
         end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
               m_result = m_pending;
               m_valid  = 1'b1;
            end
         end else if (in_valid && (!m_valid || out_ready)) begin
            if (ref_lat(alu_control, op_b) == 0) begin
               m_result = ref_val(alu_control, op_a, op_b);
               m_valid  = 1'b1;
            end else begin
               m_pending = ref_val(alu_control, op_a, op_b);
               m_busy    = ref_lat(alu_control, op_b);
               m_valid   = 1'b0;
            end
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
         #2;
         check_output("cyc out_valid", out_valid, m_valid);
         check_output("cyc busy", busy, m_busy > 0);
         check_output("cyc in_ready", in_ready, (m_busy == 0) && (!m_valid || out_ready));
         check_output("cyc result", result, m_result);
         check_output("cyc zero", zero, m_result == 32'd0);
      end
   end

   // Offer one op at the current falling edge and track it until out_valid.
   task automatic apply_stimulus(input string name, input logic [3:0] code, input logic [31:0] a,
                                 input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
      int cyc;
      int nbusy;
      in_valid    = 1'b1;
      alu_control = code;
      op_a        = a;
      op_b        = b;
      @(negedge clk);
      in_valid = 1'b0;
      op_a     = 32'hDEAD_BEEF;
      op_b     = 32'h0BAD_F00D;
      cyc      = 1;
      nbusy    = 0;
      while (!out_valid && cyc < exp_lat + 5) begin
         if (busy) nbusy++;
         @(negedge clk);
         cyc++;
      end
      check_output({name, " out_valid"}, out_valid, 1);
      check_output({name, " latency"}, cyc, exp_lat);
      check_output({name, " busy cycles"}, nbusy, exp_lat - 1);
      check_output({name, " result"}, result, exp_res);
      check_output({name, " zero"}, zero, exp_res == 32'd0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int pulses;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      alu_control = 4'd0;
      op_a        = '0;
      op_b        = '0;
      flush       = 1'b0;
      out_ready   = 1'b1;
      repeat (2) @(negedge clk);
      check_output("reset out_valid", out_valid, 0);
      check_output("reset result", result, 0);
      check_output("reset zero", zero, 1);
      check_output("reset busy", busy, 0);
      rst_n = 1'b1;
      #1;
      check_output("release in_ready", in_ready, 1);
      @(negedge clk);

      apply_stimulus("add", 4'd0, 32'd5, 32'd7, 1, 32'd12);
      apply_stimulus("sub", 4'd1, 32'd3, 32'd5, 1, 32'hFFFF_FFFE);
      apply_stimulus("slt", 4'd3, 32'hFFFF_FFFF, 32'd1, 1, 32'd1);
      apply_stimulus("sltu", 4'd4, 32'hFFFF_FFFF, 32'd1, 1, 32'd0);
      apply_stimulus("xor", 4'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 32'hFF00_FF00);
      apply_stimulus("sub_eq", 4'd1, 32'd9, 32'd9, 1, 32'd0);
      apply_stimulus("or", 4'd8, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 32'hFFF0_FFF0);
      apply_stimulus("and", 4'd9, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 32'h00F0_00F0);
      apply_stimulus("sra4", 4'd7, 32'h8000_0000, 32'd4, 5, 32'hF800_0000);
      apply_stimulus("srl4", 4'd6, 32'h8000_0000, 32'd4, 5, 32'h0800_0000);
      apply_stimulus("sll31", 4'd2, 32'd1, 32'd31, 32, 32'h8000_0000);
      apply_stimulus("undef12", 4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 1, 32'd0);
      apply_stimulus("sll_k0", 4'd2, 32'h1234_5678, 32'h0000_0020, 1, 32'h1234_5678);
      @(negedge clk);

      // Backpressure: result held while a new op waits, then handoff on the same edge.
      out_ready   = 1'b0;
      in_valid    = 1'b1;
      alu_control = 4'd0;
      op_a        = 32'd10;
      op_b        = 32'd20;
      @(negedge clk);
      alu_control = 4'd1;
      op_a        = 32'd100;
      op_b        = 32'd1;
      for (int i = 0; i < 3; i++) begin
         check_output("bp out_valid", out_valid, 1);
         check_output("bp in_ready", in_ready, 0);
         check_output("bp result", result, 32'd30);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      check_output("bp release in_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      check_output("bp next out_valid", out_valid, 1);
      check_output("bp next result", result, 32'd99);
      @(negedge clk);

      // Flush mid-shift: back to idle with no out_valid pulse, result untouched.
      in_valid    = 1'b1;
      alu_control = 4'd6;
      op_a        = 32'hFFFF_0000;
      op_b        = 32'd8;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check_output("flush pre busy", busy, 1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check_output("flush out_valid", out_valid, 0);
      check_output("flush busy", busy, 0);
      check_output("flush in_ready", in_ready, 1);
      check_output("flush result", result, 32'd99);
      pulses = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      check_output("flush no pulse", pulses, 0);

      // Flush together with an accept discards the op.
      in_valid    = 1'b1;
      flush       = 1'b1;
      alu_control = 4'd0;
      op_a        = 32'd1;
      op_b        = 32'd2;
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b0;
      check_output("flush accept out_valid", out_valid, 0);
      check_output("flush accept result", result, 32'd99);

      // Asynchronous reset in the middle of a 20-step SRL.
      in_valid    = 1'b1;
      alu_control = 4'd6;
      op_a        = 32'hFFFF_FFFF;
      op_b        = 32'd20;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      check_output("midshift busy", busy, 1);
      #1 rst_n = 1'b0;
      #1;
      check_output("async out_valid", out_valid, 0);
      check_output("async result", result, 0);
      check_output("async zero", zero, 1);
      check_output("async busy", busy, 0);
      check_output("async in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      apply_stimulus("post_reset_add", 4'd0, 32'd1, 32'd1, 1, 32'd2);
      @(negedge clk);
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
